// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// S1 forms bit P/G, S2 runs the up-sweep, S3 runs the down-sweep and the sum/flags.
module bk_adder_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned LOG_W = $clog2(WIDTH);
    localparam int unsigned IDX_W = (LOG_W < 1) ? 1 : LOG_W;

    // Up-sweep: node i with (i+1) a multiple of 2^k absorbs node i-2^(k-1).
    function automatic logic [2*WIDTH-1:0] up_sweep(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int k = 1; k <= int'(LOG_W); k++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (((i + 1) % (1 << k)) == 0) begin
                    g[IDX_W'(i)] = g[IDX_W'(i)] |
                                   (p[IDX_W'(i)] & g[IDX_W'(i - (1 << (k - 1)))]);
                    p[IDX_W'(i)] = p[IDX_W'(i)] & p[IDX_W'(i - (1 << (k - 1)))];
                end
            end
        end
        return {g, p};
    endfunction

    // Down-sweep: fills the remaining nodes from the nearest full-prefix node below.
    function automatic logic [2*WIDTH-1:0] down_sweep(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int k = int'(LOG_W) - 1; k >= 1; k--) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if ((((i + 1) % (1 << k)) == (1 << (k - 1))) && ((i + 1) > (1 << k))) begin
                    g[IDX_W'(i)] = g[IDX_W'(i)] |
                                   (p[IDX_W'(i)] & g[IDX_W'(i - (1 << (k - 1)))]);
                    p[IDX_W'(i)] = p[IDX_W'(i)] & p[IDX_W'(i - (1 << (k - 1)))];
                end
            end
        end
        return {g, p};
    endfunction

    // Stage registers
    logic             r_v1;
    logic [WIDTH-1:0] r_p1;
    logic [WIDTH-1:0] r_g1;
    logic             r_cin1;

    logic             r_v2;
    logic [WIDTH-1:0] r_gg2;
    logic [WIDTH-1:0] r_gp2;
    logic [WIDTH-1:0] r_p2;
    logic             r_cin2;

    logic             r_v3;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_en1;
    logic             w_en2;
    logic             w_en3;
    logic [WIDTH-1:0] w_b;
    logic [2*WIDTH-1:0] w_up;
    logic [2*WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_gpre;
    logic [WIDTH-1:0] w_ppre;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    // Ready chain: a stage may load when empty or when its successor moves.
    assign w_en3    = ~r_v3 | out_ready;
    assign w_en2    = ~r_v2 | w_en3;
    assign w_en1    = ~r_v1 | w_en2;
    assign in_ready = w_en1;

    assign w_b    = in_sub ? ~in_b : in_b;
    assign w_up   = up_sweep(r_g1, r_p1);
    assign w_dn   = down_sweep(r_gg2, r_gp2);
    assign w_gpre = w_dn[2*WIDTH-1:WIDTH];
    assign w_ppre = w_dn[WIDTH-1:0];

    // Every carry comes straight from its prefix term and cin, never rippled.
    assign w_carry = {w_gpre | (w_ppre & {WIDTH{r_cin2}}), r_cin2};
    assign w_sum   = r_p2 ^ w_carry[WIDTH-1:0];

    // S1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_p1   <= '0;
            r_g1   <= '0;
            r_cin1 <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_p1   <= in_a ^ w_b;
                r_g1   <= in_a & w_b;
                r_cin1 <= in_cin;
            end
        end
    end

    // S2: up-sweep result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_gg2  <= '0;
            r_gp2  <= '0;
            r_p2   <= '0;
            r_cin2 <= 1'b0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_gg2  <= w_up[2*WIDTH-1:WIDTH];
                r_gp2  <= w_up[WIDTH-1:0];
                r_p2   <= r_p1;
                r_cin2 <= r_cin1;
            end
        end
    end

    // S3: sum and flags, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
                r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
                r_zero <= ~|w_sum;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;

endmodule
